// File: rtl/prefetch_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prefetch_issuer
// Purpose  : Accepts prefetch requests from a stream predictor, filters out
//            duplicates, queues them in a small FIFO and issues them one at
//            a time to memory. Returned lines land in a small round-robin
//            prefetch buffer that demand lookups probe and consume.
// Ports    : clk, rst_n (async, active-low)
//            prefetch_v/prefetch_addr             - incoming prefetch requests
//            mem_req_v/mem_req_addr/mem_req_ready - memory read request channel
//            mem_resp_v/mem_resp_addr/mem_resp_data - memory response channel
//            demand_v/demand_addr                 - demand lookup
//            demand_hit/demand_data               - registered lookup result
//            pf_issued/pf_dropped/pf_useful       - 8-bit saturating counters,
//                                                   present only with the
//                                                   PF_STATS_EN macro defined
// Options  : `define PF_STATS_EN to add the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_issuer #(
    parameter int QDEPTH = 4,
    parameter int BUFN   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        prefetch_v,
    input  logic [15:0] prefetch_addr,
    output logic        mem_req_v,
    output logic [15:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_v,
    input  logic [15:0] mem_resp_addr,
    input  logic [15:0] mem_resp_data,
    input  logic        demand_v,
    input  logic [15:0] demand_addr,
    output logic        demand_hit,
    output logic [15:0] demand_data
`ifdef PF_STATS_EN
    ,
    output logic [7:0]  pf_issued,
    output logic [7:0]  pf_dropped,
    output logic [7:0]  pf_useful
`endif
);

    localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int BW = (BUFN > 1) ? $clog2(BUFN) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t r_state, w_next_state;

    // Request FIFO
    logic [15:0]       r_fifo_addr [QDEPTH];
    logic [QDEPTH-1:0] r_fifo_vld;
    logic [QW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [QW:0]       r_count;

    // In-flight request; doubles as the registered memory request address
    logic [15:0]       r_inflight;
    logic              r_mem_req_v;

    // Prefetch buffer
    logic [BUFN-1:0]   r_buf_vld;
    logic [15:0]       r_buf_tag  [BUFN];
    logic [15:0]       r_buf_data [BUFN];
    logic [BW-1:0]     r_rp;

    logic              r_demand_hit;
    logic [15:0]       r_demand_data;

    logic              w_full, w_empty, w_dup, w_push, w_pop, w_drop;
    logic              w_handshake, w_resp_match;
    logic              w_hit;
    logic [BW-1:0]     w_hit_idx;
    logic [15:0]       w_hit_data;

    assign w_full       = (r_count == (QW+1)'(QDEPTH));
    assign w_empty      = (r_count == '0);
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    assign w_handshake  = (r_state == S_REQ) && mem_req_ready;
    assign w_resp_match = (r_state == S_WAIT) && mem_resp_v &&
                          (mem_resp_addr == r_inflight);
    // Full is judged on pre-edge occupancy, so a same-cycle pop does not
    // make room for an incoming request.
    assign w_push       = prefetch_v && !w_full && !w_dup;
    assign w_drop       = prefetch_v && (w_full || w_dup);

    // Duplicate filter: queued entries, the in-flight address, buffered tags
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (r_fifo_vld[i] && (r_fifo_addr[i] == prefetch_addr)) begin
                w_dup = 1'b1;
            end
        end
        if ((r_state != S_IDLE) && (r_inflight == prefetch_addr)) begin
            w_dup = 1'b1;
        end
        for (int i = 0; i < BUFN; i++) begin
            if (r_buf_vld[i] && (r_buf_tag[i] == prefetch_addr)) begin
                w_dup = 1'b1;
            end
        end
    end

    // Demand lookup against pre-edge buffer contents. A line being written
    // this cycle is not yet valid, so it naturally reports a miss.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_data = '0;
        for (int i = 0; i < BUFN; i++) begin
            if (!w_hit && demand_v && r_buf_vld[i] &&
                (r_buf_tag[i] == demand_addr)) begin
                w_hit      = 1'b1;
                w_hit_idx  = BW'(i);
                w_hit_data = r_buf_data[i];
            end
        end
    end

    // Issue FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty)    w_next_state = S_REQ;
            S_REQ:   if (w_handshake) w_next_state = S_WAIT;
            S_WAIT:  if (w_resp_match) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Issue FSM: state register; request valid is registered off next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mem_req_v <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_mem_req_v <= (w_next_state == S_REQ);
        end
    end

    // Request FIFO and in-flight register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_fifo_addr[i] <= '0;
            end
            r_fifo_vld <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= prefetch_addr;
                r_fifo_vld[r_wr_ptr]  <= 1'b1;
                r_wr_ptr              <= r_wr_ptr + QW'(1);
            end
            if (w_pop) begin
                r_fifo_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr             <= r_rd_ptr + QW'(1);
                r_inflight           <= r_fifo_addr[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (QW+1)'(1);
                2'b01:   r_count <= r_count - (QW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Prefetch buffer. The consume is applied before the fill so that a
    // same-slot collision leaves the freshly written line valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUFN; i++) begin
                r_buf_tag[i]  <= '0;
                r_buf_data[i] <= '0;
            end
            r_buf_vld     <= '0;
            r_rp          <= '0;
            r_demand_hit  <= 1'b0;
            r_demand_data <= '0;
        end else begin
            if (w_hit) begin
                r_buf_vld[w_hit_idx] <= 1'b0;
            end
            if (w_resp_match) begin
                r_buf_vld[r_rp]  <= 1'b1;
                r_buf_tag[r_rp]  <= mem_resp_addr;
                r_buf_data[r_rp] <= mem_resp_data;
                if (r_rp == BW'(BUFN - 1)) begin
                    r_rp <= '0;
                end else begin
                    r_rp <= r_rp + BW'(1);
                end
            end
            r_demand_hit  <= w_hit;
            r_demand_data <= w_hit ? w_hit_data : 16'h0000;
        end
    end

    assign mem_req_v    = r_mem_req_v;
    assign mem_req_addr = r_inflight;
    assign demand_hit   = r_demand_hit;
    assign demand_data  = r_demand_data;

`ifdef PF_STATS_EN
    logic [7:0] r_pf_issued, r_pf_dropped, r_pf_useful;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pf_issued  <= '0;
            r_pf_dropped <= '0;
            r_pf_useful  <= '0;
        end else begin
            if (w_handshake && (r_pf_issued != 8'hFF)) begin
                r_pf_issued <= r_pf_issued + 8'd1;
            end
            if (w_drop && (r_pf_dropped != 8'hFF)) begin
                r_pf_dropped <= r_pf_dropped + 8'd1;
            end
            if (w_hit && (r_pf_useful != 8'hFF)) begin
                r_pf_useful <= r_pf_useful + 8'd1;
            end
        end
    end

    assign pf_issued  = r_pf_issued;
    assign pf_dropped = r_pf_dropped;
    assign pf_useful  = r_pf_useful;
`else
    // Drop detection only feeds the statistics counters.
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prefetch_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_prefetch_issuer
// Purpose  : Self-checking bench for prefetch_issuer. Issued memory requests
//            are checked against a queue of expected addresses; fill/demand
//            pairs come from a vector table; multi-cycle corner cases are
//            hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prefetch_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        prefetch_v = 1'b0;
    logic [15:0] prefetch_addr = '0;
    logic        mem_req_v;
    logic [15:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_v = 1'b0;
    logic [15:0] mem_resp_addr = '0;
    logic [15:0] mem_resp_data = '0;
    logic        demand_v = 1'b0;
    logic [15:0] demand_addr = '0;
    logic        demand_hit;
    logic [15:0] demand_data;
`ifdef PF_STATS_EN
    logic [7:0]  pf_issued, pf_dropped, pf_useful;
`endif

    always #5 clk = ~clk;

    prefetch_issuer #(.QDEPTH(4), .BUFN(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .prefetch_v    (prefetch_v),
        .prefetch_addr (prefetch_addr),
        .mem_req_v     (mem_req_v),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_v    (mem_resp_v),
        .mem_resp_addr (mem_resp_addr),
        .mem_resp_data (mem_resp_data),
        .demand_v      (demand_v),
        .demand_addr   (demand_addr),
        .demand_hit    (demand_hit),
        .demand_data   (demand_data)
`ifdef PF_STATS_EN
        ,
        .pf_issued     (pf_issued),
        .pf_dropped    (pf_dropped),
        .pf_useful     (pf_useful)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_hs     = 0;
    logic [15:0] sb_q [$];

    typedef struct {
        logic [15:0] pf_addr;
        logic [15:0] pf_data;
        logic [15:0] dem_addr;
        logic        exp_hit;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue monitor: every handshake must match the next expected address
    always @(negedge clk) begin
        if (rst_n && mem_req_v && mem_req_ready) begin
            n_hs++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL issue_unexpected: got %h expected none", mem_req_addr);
            end else begin
                chk("issue_addr", mem_req_addr, sb_q.pop_front());
            end
        end
    end

    task automatic wait_req(output logic ok);
        int cyc = 0;
        while (!mem_req_v && cyc < 20) begin
            step();
            cyc++;
        end
        ok = mem_req_v;
        if (!ok) fail("req_timeout");
    endtask

    // Accept the pending request, then respond two cycles after the request
    task automatic hs_respond(input logic [15:0] addr, input logic [15:0] data);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("req_v_after_hs", {15'd0, mem_req_v}, 16'd0);
        step();
        mem_resp_v    = 1'b1;
        mem_resp_addr = addr;
        mem_resp_data = data;
        step();
        mem_resp_v    = 1'b0;
    endtask

    // Prefetch into an empty, idle issuer: request must appear two cycles on
    task automatic fill(input logic [15:0] addr, input logic [15:0] data);
        logic ok;
        prefetch_v    = 1'b1;
        prefetch_addr = addr;
        sb_q.push_back(addr);
        step();
        prefetch_v = 1'b0;
        chk("latency_c1", {15'd0, mem_req_v}, 16'd0);
        step();
        chk("latency_c2", {15'd0, mem_req_v}, 16'd1);
        wait_req(ok);
        if (ok) hs_respond(addr, data);
        else sb_q.delete();
    endtask

    task automatic demand(input string name, input logic [15:0] addr,
                          input logic exp_hit, input logic [15:0] exp_data);
        demand_v    = 1'b1;
        demand_addr = addr;
        step();
        demand_v = 1'b0;
        chk({name, "_hit"}, {15'd0, demand_hit}, {15'd0, exp_hit});
        chk({name, "_data"}, demand_data, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   hs0;
`ifdef PF_STATS_EN
        logic [7:0] drop0;
`endif
        vecs[0] = '{16'h1000, 16'hBEEF, 16'h1000, 1'b1, 16'hBEEF};
        vecs[1] = '{16'h1100, 16'h1234, 16'h1000, 1'b0, 16'h0000};
        vecs[2] = '{16'h1200, 16'h5555, 16'h1100, 1'b1, 16'h1234};
        vecs[3] = '{16'h1300, 16'h0AAA, 16'h1999, 1'b0, 16'h0000};
        vecs[4] = '{16'h1400, 16'h7777, 16'h1400, 1'b1, 16'h7777};

        // Asynchronous reset, observed before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_v", {15'd0, mem_req_v}, 16'd0);
        chk("rst_req_addr", mem_req_addr, 16'h0000);
        chk("rst_hit", {15'd0, demand_hit}, 16'd0);
        chk("rst_data", demand_data, 16'h0000);
`ifdef PF_STATS_EN
        chk("rst_issued", {8'd0, pf_issued}, 16'd0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

        // Table: fill one line then probe
        for (int i = 0; i < 5; i++) begin
            fill(vecs[i].pf_addr, vecs[i].pf_data);
            demand($sformatf("vec%0d", i), vecs[i].dem_addr, vecs[i].exp_hit, vecs[i].exp_data);
        end

        // Duplicates: three back-to-back prefetches of one address
        hs0 = n_hs;
`ifdef PF_STATS_EN
        drop0 = pf_dropped;
`endif
        prefetch_v    = 1'b1;
        prefetch_addr = 16'h2000;
        sb_q.push_back(16'h2000);
        step();
        step();
        step();
        prefetch_v = 1'b0;
        wait_req(ok);
        if (ok) hs_respond(16'h2000, 16'h2222);
        step();
        chk("dup_handshakes", 16'(n_hs - hs0), 16'd1);
`ifdef PF_STATS_EN
        chk("dup_dropped", {8'd0, pf_dropped - drop0}, 16'd2);
`endif
        demand("dup_demand", 16'h2000, 1'b1, 16'h2222);

        // Overflow: memory stalled while six requests arrive
        mem_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            prefetch_v    = 1'b1;
            prefetch_addr = 16'((i + 1) * 16'h10);
            if (i < 5) sb_q.push_back(16'((i + 1) * 16'h10));
            step();
        end
        prefetch_v = 1'b0;
        chk("ovf_req_v", {15'd0, mem_req_v}, 16'd1);
        chk("ovf_req_addr", mem_req_addr, 16'h0010);
        step();
        step();
        chk("ovf_addr_stable", mem_req_addr, 16'h0010);
        for (int k = 0; k < 5; k++) begin
            wait_req(ok);
            if (ok) hs_respond(16'((k + 1) * 16'h10), 16'(16'h0100 + k));
        end
        step();
        step();
        step();
        chk("ovf_no_extra_req", {15'd0, mem_req_v}, 16'd0);
        chk("ovf_sb_empty", 16'(sb_q.size()), 16'd0);

        // Replacement: fifth fill overwrites the oldest slot
        for (int j = 0; j < 5; j++) begin
            fill(16'(16'h00A0 + j), 16'(16'h00D0 + j));
        end
        demand("repl_a0", 16'h00A0, 1'b0, 16'h0000);
        demand("repl_a4", 16'h00A4, 1'b1, 16'h00D4);

        // Protocol: mismatched response is ignored, FSM stays in WAIT
        prefetch_v    = 1'b1;
        prefetch_addr = 16'h3000;
        sb_q.push_back(16'h3000);
        step();
        prefetch_v = 1'b0;
        wait_req(ok);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_resp_v    = 1'b1;
        mem_resp_addr = 16'h3004;
        mem_resp_data = 16'h1111;
        step();
        mem_resp_v    = 1'b0;
        prefetch_v    = 1'b1;
        prefetch_addr = 16'h3100;
        sb_q.push_back(16'h3100);
        step();
        prefetch_v = 1'b0;
        step();
        step();
        chk("proto_still_wait", {15'd0, mem_req_v}, 16'd0);
        mem_resp_v    = 1'b1;
        mem_resp_addr = 16'h3000;
        mem_resp_data = 16'h3333;
        step();
        mem_resp_v = 1'b0;
        wait_req(ok);
        if (ok) hs_respond(16'h3100, 16'h3131);
        demand("proto_3004", 16'h3004, 1'b0, 16'h0000);
        demand("proto_3000", 16'h3000, 1'b1, 16'h3333);

        // Same-cycle response and demand: miss now, hit afterwards
        prefetch_v    = 1'b1;
        prefetch_addr = 16'h4000;
        sb_q.push_back(16'h4000);
        step();
        prefetch_v = 1'b0;
        wait_req(ok);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        mem_resp_v    = 1'b1;
        mem_resp_addr = 16'h4000;
        mem_resp_data = 16'h4444;
        demand_v      = 1'b1;
        demand_addr   = 16'h4000;
        step();
        mem_resp_v = 1'b0;
        demand_v   = 1'b0;
        chk("same_cyc_hit", {15'd0, demand_hit}, 16'd0);
        demand("after_fill", 16'h4000, 1'b1, 16'h4444);

        // Reset mid-REQ abandons the request; stale response is ignored
        prefetch_v    = 1'b1;
        prefetch_addr = 16'h3000;
        step();
        prefetch_v = 1'b0;
        wait_req(ok);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req_v", {15'd0, mem_req_v}, 16'd0);
        chk("rst_mid_req_addr", mem_req_addr, 16'h0000);
        step();
        rst_n = 1'b1;
        step();
        mem_resp_v    = 1'b1;
        mem_resp_addr = 16'h3000;
        mem_resp_data = 16'h5A5A;
        step();
        mem_resp_v = 1'b0;
        demand("stale_resp", 16'h3000, 1'b0, 16'h0000);
        demand("buf_cleared", 16'h1200, 1'b0, 16'h0000);
        step();
        chk("post_rst_idle", {15'd0, mem_req_v}, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prefetch_issuer.md
PREFETCH_ISSUER -- requirements
Module: prefetch_issuer

Interface
REQ-001 Parameters SHALL be:
- QDEPTH, default 4: request queue entries (power of two).
- BUFN, default 4: prefetch buffer entries.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- prefetch_v  in  1  prefetch request valid, from the ISB stream predictor.
- prefetch_addr  in  16  requested address.
- mem_req_v  out  1  memory read request valid.
- mem_req_addr  out  16  memory read address.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_v  in  1  memory response valid.
- mem_resp_addr  in  16  response address.
- mem_resp_data  in  16  response data.
- demand_v  in  1  demand lookup valid.
- demand_addr  in  16  demand lookup address.
- demand_hit  out  1  registered hit result.
- demand_data  out  16  registered hit data.

Function
REQ-003 The block SHALL push a request into a QDEPTH-entry FIFO when prefetch_v=1, the FIFO is not full, and the address is not a duplicate.
REQ-004 Duplicate SHALL mean prefetch_addr matches any of: a valid FIFO entry, the in-flight address (state REQ or WAIT), or a valid buffer tag; duplicates are dropped.
REQ-005 Full SHALL be evaluated on pre-edge state; a request arriving when full is dropped even if a pop occurs in the same cycle.
REQ-006 The FIFO pointers SHALL be log2(QDEPTH) bits wide and wrap modulo QDEPTH; the count is log2(QDEPTH)+1 bits.
REQ-007 The issue FSM SHALL have states IDLE, REQ and WAIT:
- IDLE->REQ when the FIFO is non-empty; pop the head into the in-flight register.
- REQ holds mem_req_v=1 with a stable mem_req_addr until mem_req_ready=1, then goes to WAIT.
- WAIT->IDLE on mem_resp_v=1 with mem_resp_addr equal to the in-flight address.
REQ-008 At most one memory request SHALL be outstanding.
REQ-009 mem_req_v SHALL be 1 only in REQ and SHALL be driven from a register.
REQ-010 A response with mismatched address, or arriving outside WAIT, SHALL be ignored.
REQ-011 A matching response SHALL write {valid, addr, data} into the buffer entry at a round-robin replacement pointer, overwriting that entry if valid. The pointer then increments modulo BUFN.
REQ-012 Demand lookup SHALL compare demand_addr against valid buffer tags using pre-edge state. On the next cycle: demand_hit=1 and demand_data=entry data on a hit; demand_hit=0 and demand_data=0 otherwise.
REQ-013 A hit entry SHALL be invalidated (consumed) at the same edge.
REQ-014 A demand to an address that is in-flight, queued, or being written by a same-cycle response SHALL report a miss; the response write still occurs.
REQ-015 A same-cycle demand hit and response write targeting the same buffer slot SHALL leave the slot holding the new response (write wins).
REQ-016 Latency from prefetch_v to mem_req_v SHALL be 2 cycles when the FIFO is empty and the FSM is in IDLE.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for clk, produce: FSM=IDLE; mem_req_v=0; mem_req_addr=0; demand_hit=0; demand_data=0; FIFO empty; all buffer entries invalid; replacement pointer=0.
REQ-018 Reset during REQ or WAIT SHALL abandon the transaction; a later response for it is ignored (per REQ-010).

Configuration
REQ-019 With PF_STATS_EN defined, the block SHALL add three 8-bit saturating output counters, all reset to 0:
- pf_issued: increments on each mem_req_v and mem_req_ready handshake.
- pf_dropped: increments on each full or duplicate drop.
- pf_useful: increments on each demand hit.
REQ-020 Without PF_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-021 Issue and fill: prefetch 0x1000; mem_req_ready=1 on the first REQ cycle; response 0x1000/0xBEEF two cycles later; then demand 0x1000 -> demand_hit=1 with data 0xBEEF; a second demand 0x1000 -> demand_hit=0.
REQ-022 Duplicates: prefetch 0x2000 on three consecutive cycles -> exactly one mem_req handshake for 0x2000; pf_dropped=2 (stats build).
REQ-023 Overflow: mem_req_ready=0; prefetch 0x10,0x20,0x30,0x40,0x50,0x60 -> 0x10 in flight, 0x20-0x50 queued, 0x60 dropped; after ready is asserted, issue order is 0x10,0x20,0x30,0x40,0x50.
REQ-024 Replacement: fill 0xA0,0xA1,0xA2,0xA3,0xA4 -> demand 0xA0 misses and demand 0xA4 hits.
REQ-025 Protocol: in WAIT for 0x3000, response 0x3004 -> ignored and FSM stays in WAIT; then response 0x3000 -> FSM returns to IDLE.
REQ-026 Reset: assert rst_n=0 mid-REQ -> mem_req_v=0 before the next clk edge; after release, a stale response 0x3000 creates no buffer entry.
